// File: rtl/dm_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// dm_responder : data-memory responder with programmable wait states
// Revision 1.0
// ============================================================================
module dm_responder #(
    parameter int LATENCY     = 2,
    parameter int DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_sel,
    input  logic [9:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int         IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] C_WAIT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
    localparam bit         C_ZERO_LAT  = (LATENCY == 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [1:0]  sel_q;
    logic [9:0]  addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        capture;
    logic        commit;

    logic [31:0] mem_q [DEPTH_WORDS];

    // With zero latency the accept edge is also the commit edge, so the live
    // request fields are used; otherwise the captured copy is.
    logic        op_we;
    logic [1:0]  op_sel;
    logic [9:0]  op_addr;
    logic [31:0] op_wdata;

    always_comb begin
        op_we    = we_q;
        op_sel   = sel_q;
        op_addr  = addr_q;
        op_wdata = wdata_q;
        if (state_q == S_IDLE) begin
            op_we    = req_we;
            op_sel   = req_sel;
            op_addr  = req_addr;
            op_wdata = req_wdata;
        end
    end

    logic [IDX_W-1:0] idx;
    logic [1:0]       lane;
    logic [31:0]      cur_word;
    logic [31:0]      lane_shift;
    logic [7:0]       cur_byte;
    logic             op_err;
    logic [31:0]      wr_word;
    logic [31:0]      load_data;

    assign idx        = IDX_W'({1'b0, op_addr[9:2]} % 9'(DEPTH_WORDS));
    assign lane       = op_addr[1:0];
    assign cur_word   = mem_q[idx];
    assign lane_shift = cur_word >> {lane, 3'b000};
    assign cur_byte   = lane_shift[7:0];
    assign op_err     = (op_sel == 2'b11) || ((op_sel == 2'b00) && (lane != 2'b00));

    always_comb begin
        wr_word = cur_word;
        if (op_sel == 2'b00) begin
            wr_word = op_wdata;
        end else begin
            case (lane)
                2'd0:    wr_word[7:0]   = op_wdata[7:0];
                2'd1:    wr_word[15:8]  = op_wdata[7:0];
                2'd2:    wr_word[23:16] = op_wdata[7:0];
                default: wr_word[31:24] = op_wdata[7:0];
            endcase
        end
    end

    always_comb begin
        case (op_sel)
            2'b00:   load_data = cur_word;
            2'b01:   load_data = {{24{cur_byte[7]}}, cur_byte};
            2'b10:   load_data = {24'd0, cur_byte};
            default: load_data = 32'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        commit  = 1'b0;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    capture = 1'b1;
                    if (C_ZERO_LAT) begin
                        state_d = S_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = C_WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                rdata_d = 32'd0;
                err_d   = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
        if (commit) begin
            rdata_d = (op_we || op_err) ? 32'd0 : load_data;
            err_d   = op_err;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            sel_q   <= 2'b00;
            addr_q  <= 10'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (capture) begin
                we_q    <= req_we;
                sel_q   <= req_sel;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

    // Array has no reset; a held-low rst must still block a zero-latency commit.
    always_ff @(posedge clk) begin
        if (commit && op_we && !op_err && rst) begin
            mem_q[idx] <= wr_word;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dm_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_dm_responder : self-checking bench, LATENCY=2 and LATENCY=0/DEPTH=128
// Revision 1.0
// ============================================================================
module tb_dm_responder;

    localparam int LAT_A = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        a_valid, a_ready, a_we, a_rvalid, a_err;
    logic [1:0]  a_sel;
    logic [9:0]  a_addr;
    logic [31:0] a_wdata, a_rdata;

    logic        b_valid, b_ready, b_we, b_rvalid, b_err;
    logic [1:0]  b_sel;
    logic [9:0]  b_addr;
    logic [31:0] b_wdata, b_rdata;

    dm_responder #(.LATENCY(LAT_A), .DEPTH_WORDS(256)) u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (a_valid),
        .req_ready  (a_ready),
        .req_we     (a_we),
        .req_sel    (a_sel),
        .req_addr   (a_addr),
        .req_wdata  (a_wdata),
        .resp_valid (a_rvalid),
        .resp_rdata (a_rdata),
        .resp_err   (a_err)
    );

    dm_responder #(.LATENCY(0), .DEPTH_WORDS(128)) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (b_valid),
        .req_ready  (b_ready),
        .req_we     (b_we),
        .req_sel    (b_sel),
        .req_addr   (b_addr),
        .req_wdata  (b_wdata),
        .resp_valid (b_rvalid),
        .resp_rdata (b_rdata),
        .resp_err   (b_err)
    );

    typedef struct {
        logic        we;
        logic [1:0]  sel;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs[20];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1 && a_rvalid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_resp", 64'd1, 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("resp", {31'd0, a_err, a_rdata}, {31'd0, mon_e.err, mon_e.rdata});
            end
        end
    end

    task automatic wait_a_ready();
        int k;
        k = 0;
        @(negedge clk);
        while (a_ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("ready_wait", {63'd0, a_ready}, 64'd1);
    endtask

    task automatic drive_a(input vec_t v);
        a_we    = v.we;
        a_sel   = v.sel;
        a_addr  = v.addr;
        a_wdata = v.wdata;
        a_valid = 1'b1;
        @(posedge clk);
        #1 a_valid = 1'b0;
    endtask

    task automatic issue_a(input vec_t v);
        int lat;
        bit busy_ok;
        wait_a_ready();
        sb_q.push_back('{rdata: v.exp_rdata, err: v.exp_err});
        drive_a(v);
        lat     = 0;
        busy_ok = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (a_ready !== 1'b0) busy_ok = 1'b0;
            if (a_rvalid === 1'b1) begin
                lat = c;
                break;
            end
        end
        chk("latency", 64'(lat), 64'(LAT_A + 1));
        chk("ready_low", {63'd0, busy_ok}, 64'd1);
        @(negedge clk);
        chk("resp_clear", {29'd0, a_rvalid, a_ready, a_err, a_rdata}, {29'd0, 1'b0, 1'b1, 1'b0, 32'd0});
    endtask

    task automatic issue_b(input string name, input logic we, input logic [1:0] sel,
                           input logic [9:0] addr, input logic [31:0] wdata, input logic [31:0] exp);
        @(negedge clk);
        b_we    = we;
        b_sel   = sel;
        b_addr  = addr;
        b_wdata = wdata;
        b_valid = 1'b1;
        @(posedge clk);
        #1 b_valid = 1'b0;
        @(negedge clk);
        chk(name, {30'd0, b_rvalid, b_err, b_rdata}, {30'd0, 1'b1, 1'b0, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        vec_t v;
        logic e_rv;

        vecs[0]  = '{1'b1, 2'b00, 10'h010, 32'hDEADBEEF, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b0, 2'b00, 10'h010, 32'h00000000, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 2'b01, 10'h011, 32'h000000A5, 32'h00000000, 1'b0};
        vecs[3]  = '{1'b0, 2'b00, 10'h010, 32'h00000000, 32'hDEADA5EF, 1'b0};
        vecs[4]  = '{1'b0, 2'b01, 10'h011, 32'h00000000, 32'hFFFFFFA5, 1'b0};
        vecs[5]  = '{1'b0, 2'b10, 10'h011, 32'h00000000, 32'h000000A5, 1'b0};
        vecs[6]  = '{1'b0, 2'b00, 10'h012, 32'h00000000, 32'h00000000, 1'b1};
        vecs[7]  = '{1'b0, 2'b11, 10'h010, 32'h00000000, 32'h00000000, 1'b1};
        vecs[8]  = '{1'b1, 2'b00, 10'h014, 32'hA0A0A0A0, 32'h00000000, 1'b0};
        vecs[9]  = '{1'b1, 2'b00, 10'h016, 32'h12345678, 32'h00000000, 1'b1};
        vecs[10] = '{1'b0, 2'b00, 10'h014, 32'h00000000, 32'hA0A0A0A0, 1'b0};
        vecs[11] = '{1'b1, 2'b10, 10'h017, 32'hFFFFFF3C, 32'h00000000, 1'b0};
        vecs[12] = '{1'b0, 2'b00, 10'h014, 32'h00000000, 32'h3CA0A0A0, 1'b0};
        vecs[13] = '{1'b0, 2'b01, 10'h017, 32'h00000000, 32'h0000003C, 1'b0};
        vecs[14] = '{1'b0, 2'b01, 10'h014, 32'h00000000, 32'hFFFFFFA0, 1'b0};
        vecs[15] = '{1'b1, 2'b00, 10'h3FC, 32'h0BADCAFE, 32'h00000000, 1'b0};
        vecs[16] = '{1'b0, 2'b00, 10'h3FC, 32'h00000000, 32'h0BADCAFE, 1'b0};
        vecs[17] = '{1'b0, 2'b10, 10'h3FE, 32'h00000000, 32'h000000AD, 1'b0};
        vecs[18] = '{1'b1, 2'b11, 10'h010, 32'h00000000, 32'h00000000, 1'b1};
        vecs[19] = '{1'b0, 2'b00, 10'h010, 32'h00000000, 32'hDEADA5EF, 1'b0};

        rst = 1'b0;
        a_valid = 1'b0; a_we = 1'b0; a_sel = 2'b00; a_addr = 10'd0; a_wdata = 32'd0;
        b_valid = 1'b0; b_we = 1'b0; b_sel = 2'b00; b_addr = 10'd0; b_wdata = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_a", {29'd0, a_ready, a_rvalid, a_err, a_rdata}, {29'd0, 1'b1, 1'b0, 1'b0, 32'd0});
        chk("reset_b", {29'd0, b_ready, b_rvalid, b_err, b_rdata}, {29'd0, 1'b1, 1'b0, 1'b0, 32'd0});
        rst = 1'b1;

        for (int i = 0; i < 20; i++) issue_a(vecs[i]);

        // Reset while the second store is still waiting: it must never land.
        issue_a('{1'b1, 2'b00, 10'h020, 32'h11111111, 32'h0, 1'b0});
        wait_a_ready();
        drive_a('{1'b1, 2'b00, 10'h020, 32'h22222222, 32'h0, 1'b0});
        @(posedge clk);
        #2 rst = 1'b0;
        #1 chk("rst_in_wait", {29'd0, a_ready, a_rvalid, a_err, a_rdata}, {29'd0, 1'b1, 1'b0, 1'b0, 32'd0});
        @(negedge clk);
        chk("rst_held", {29'd0, a_ready, a_rvalid, a_err, a_rdata}, {29'd0, 1'b1, 1'b0, 1'b0, 32'd0});
        @(negedge clk);
        rst = 1'b1;
        issue_a('{1'b0, 2'b00, 10'h020, 32'h0, 32'h11111111, 1'b0});

        // Reset during the response cycle: strobe drops, the write stands.
        wait_a_ready();
        sb_q.push_back('{rdata: 32'h0, err: 1'b0});
        drive_a('{1'b1, 2'b00, 10'h024, 32'h44444444, 32'h0, 1'b0});
        k = 0;
        @(negedge clk);
        while (a_rvalid !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("resp_seen", {63'd0, a_rvalid}, 64'd1);
        #1 rst = 1'b0;
        #1 chk("rst_in_resp", {29'd0, a_ready, a_rvalid, a_err, a_rdata}, {29'd0, 1'b1, 1'b0, 1'b0, 32'd0});
        @(negedge clk);
        rst = 1'b1;
        issue_a('{1'b0, 2'b00, 10'h024, 32'h0, 32'h44444444, 1'b0});

        // Zero-latency instance, req_valid held high: accept every other edge.
        @(negedge clk);
        b_we = 1'b1; b_sel = 2'b00; b_addr = 10'h3FC; b_wdata = 32'hCAFEF00D; b_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            e_rv = (i % 2 == 0);
            chk($sformatf("b_b2b_%0d", i), {29'd0, b_rvalid, b_ready, b_err, b_rdata},
                {29'd0, e_rv, ~e_rv, 1'b0, 32'd0});
        end
        b_valid = 1'b0;
        issue_b("b_alias_1fc", 1'b0, 2'b00, 10'h1FC, 32'd0, 32'hCAFEF00D);
        issue_b("b_load_3fc",  1'b0, 2'b00, 10'h3FC, 32'd0, 32'hCAFEF00D);
        issue_b("b_byte_sext", 1'b0, 2'b01, 10'h1FD, 32'd0, 32'hFFFFFFF0);

        repeat (2) @(negedge clk);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
